// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: round-robin grant between packets, lock held on
// the owner for multi-beat packets, and a per-requestor packet quota before priority advances.
module wrr_pkt_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned PRI_RST = 0,
  parameter int unsigned W_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            request,
  input  logic [N-1:0]            last,
  input  logic [N*W_BITS-1:0]     weight,
  input  logic                    ready,
  output logic [N-1:0]            grant,
  output logic [$clog2(N)-1:0]    grant_id,
  output logic                    anygnt,
  output logic                    locked
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = W_BITS + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    hold_q, hold_d;
  logic [W_BITS-1:0] cnt_q, cnt_d;

  logic [IDW-1:0]    ptr_idx;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_vld;
  logic [W_BITS-1:0] w_eff;
  logic [CW-1:0]     n_cnt;

  // Binary index of the one-hot priority pointer.
  always_comb begin
    ptr_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IDW'(i);
    end
  end

  // Grant selection: owner only while locked, rotating search from ptr otherwise.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == LOCKED) begin
      gnt_vld = request[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int unsigned off = 0; off < N; off++) begin
        cand = IDW'((32'(ptr_idx) + off) % N);
        if (!gnt_vld && request[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    grant    = gnt_vld ? (N'(1) << gnt_idx) : '0;
    grant_id = gnt_vld ? gnt_idx : '0;
    anygnt   = gnt_vld;
  end

  assign locked = (state_q == LOCKED);

  // Next-state: lock on a non-final beat, quota accounting on packet completion.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    w_eff   = '0;
    n_cnt   = '0;
    if (gnt_vld && ready) begin
      if (!last[gnt_idx]) begin
        state_d = LOCKED;
        owner_d = gnt_idx;
      end else begin
        state_d = IDLE;
        for (int unsigned i = 0; i < N; i++) begin
          if (IDW'(i) == gnt_idx) w_eff = weight[i*W_BITS +: W_BITS];
        end
        if (w_eff == '0) w_eff = W_BITS'(1);
        n_cnt = (gnt_idx == hold_q) ? (CW'(cnt_q) + CW'(1)) : CW'(1);
        if (n_cnt >= CW'(w_eff)) begin
          ptr_d = (gnt_idx == IDW'(N - 1)) ? N'(1) : (N'(1) << (32'(gnt_idx) + 1));
          cnt_d = '0;
        end else begin
          ptr_d  = N'(1) << gnt_idx;
          hold_d = gnt_idx;
          cnt_d  = n_cnt[W_BITS-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= N'(1) << PRI_RST;
      owner_q <= '0;
      hold_q  <= IDW'(PRI_RST);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/wrr_pkt_arbiter.md
WRR_PKT_ARBITER -- requirements
Module: wrr_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requestors (legal range 2..32).
REQ-002 The block SHALL have parameter PRI_RST, default 0, meaning the requestor index holding priority after reset (legal range 0..N-1).
REQ-003 The block SHALL have parameter W_BITS, default 3, meaning the width of each per-requestor weight.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port request, input, N bits: per-requestor request.
REQ-007 The block SHALL have port last, input, N bits: the current beat of requestor i is the final beat of its packet.
REQ-008 The block SHALL have port weight, input, N*W_BITS bits: slice i is the packet quota of requestor i.
REQ-009 The block SHALL have port ready, input, 1 bit: downstream accepts the granted beat this cycle.
REQ-010 The block SHALL have port grant, output, N bits: at-most-one-hot grant.
REQ-011 The block SHALL have port grant_id, output, $clog2(N) bits: binary index of the granted requestor (0 when grant is 0).
REQ-012 The block SHALL have port anygnt, output, 1 bit: OR-reduction of grant.
REQ-013 The block SHALL have port locked, output, 1 bit: high while in state LOCKED.

Function
REQ-014 State SHALL comprise: FSM {IDLE, LOCKED}; one-hot priority pointer ptr; owner index; hold index; packet counter cnt (W_BITS bits).
REQ-015 In IDLE, grant SHALL be combinational round-robin: search request from ptr position i in order i..N-1, 0..i-1; the first set bit wins.
REQ-016 In LOCKED, grant SHALL be the one-hot of owner when request[owner]=1, else 0; other requests SHALL be ignored.
REQ-017 A transfer SHALL occur in a cycle with grant[k]=1 and ready=1; no state changes without a transfer (except reset).
REQ-018 Transfer with last[k]=0 SHALL enter LOCKED with owner=k, or remain in LOCKED.
REQ-019 Transfer with last[k]=1 SHALL leave the FSM in IDLE next cycle and complete a packet for k.
REQ-020 Effective weight W(k) SHALL be weight slice k, with value 0 treated as 1; it SHALL be sampled in the completion cycle.
REQ-021 On packet completion by k, n SHALL be cnt+1 if k==hold, else 1.
REQ-022 On completion, if n>=W(k), ptr SHALL become one-hot (k+1) mod N and cnt SHALL become 0.
REQ-023 On completion, otherwise ptr SHALL become one-hot k, hold SHALL become k, and cnt SHALL become n.
REQ-024 A single-beat packet (last=1 on the first transfer) SHALL complete without entering LOCKED.
REQ-025 Request deassertion by owner while LOCKED SHALL give grant=0 and anygnt=0, with the FSM held in LOCKED (bubble, no preemption).
REQ-026 With no request in IDLE, outputs SHALL be grant=0, grant_id=0, anygnt=0, and state SHALL be unchanged.
REQ-027 ready=0 with a valid grant SHALL hold the grant stable and change no state.
REQ-028 Pointer wrap SHALL work as follows: completion by N-1 moving priority sets ptr to one-hot 0.
REQ-029 grant, grant_id and anygnt SHALL be combinational (zero-cycle latency from request); ptr, FSM and cnt updates SHALL take effect on the next cycle.

Reset
REQ-030 With rst=1 at a clock edge, state SHALL become IDLE, ptr=1<<PRI_RST, cnt=0, hold=PRI_RST, owner=0, locked=0.
REQ-031 Reset mid-packet SHALL abandon the lock; the next cycle SHALL arbitrate from PRI_RST.
REQ-032 While rst=1, outputs SHALL still follow the IDLE combinational rules using the reset pointer after the first reset edge.

Verification
REQ-033 Scenario: N=4, PRI_RST=0, all weights=1, request=1111, last=1111, ready=1 for 5 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-034 Scenario: weight[0]=3, other weights=1, request=0011, single-beat packets -> grant 0001 for 3 cycles, then 0010, then 0001.
REQ-035 Scenario: request=0101, req0 sends 3-beat packet (last at beat 3) -> grant 0001 for 3 transfers with locked=1 on beats 2-3, then 0100.
REQ-036 Scenario: LOCKED on owner 2, request[2] drops for 2 cycles while request=1011 -> grant 0000, anygnt=0, locked=1; then request[2] returns with last=1 -> grant 0100, then IDLE.
REQ-037 Scenario: ready=0 for 3 cycles with request=0110 -> grant held at 0010, ptr unchanged; ready=1 -> transfer, next grant 0100.
REQ-038 Scenario: reset asserted while LOCKED on owner 3, PRI_RST=1 -> locked=0 next cycle and request=1111 yields grant 0010.
